// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parametrised single-clock FIFO with FWFT option, thresholds and sticky errors
module sync_fifo #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       fifo_empty,
    output logic                       fifo_full,
    output logic                       fifo_almost_empty,
    output logic                       fifo_almost_full,
    output logic                       fifo_overrun,
    output logic                       fifo_underrun,
    output logic [$clog2(DEPTH):0]     fifo_data_num,
    output logic [$clog2(DEPTH):0]     fifo_room_num
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovr_q, ovr_d;
    logic              udr_q, udr_d;
    logic              wa, ra;

    assign fifo_empty        = (cnt_q == '0);
    assign fifo_full         = (cnt_q == FULL_CNT);
    assign fifo_almost_empty = (cnt_q <= AE_CNT);
    assign fifo_almost_full  = (cnt_q >= AF_CNT);
    assign fifo_data_num     = cnt_q;
    assign fifo_room_num     = FULL_CNT - cnt_q;
    assign fifo_overrun      = ovr_q;
    assign fifo_underrun     = udr_q;

    // The reset term keeps the un-reset memory from being written while in reset.
    assign wa = wr_en && !fifo_full && sys_rst_n;
    assign ra = rd_en && !fifo_empty && sys_rst_n;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        udr_d    = udr_q;
        if (wa) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (ra) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (wa && !ra) begin
            cnt_d = cnt_q + (ADDR_W+1)'(1);
        end else if (ra && !wa) begin
            cnt_d = cnt_q - (ADDR_W+1)'(1);
        end
        // Set has priority over clear.
        if (wr_en && fifo_full) begin
            ovr_d = 1'b1;
        end else if (err_clr) begin
            ovr_d = 1'b0;
        end
        if (rd_en && fifo_empty) begin
            udr_d = 1'b1;
        end else if (err_clr) begin
            udr_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            udr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            udr_q    <= udr_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wa) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Forced to zero while empty so the output matches its reset value.
            assign rd_data  = fifo_empty ? '0 : mem[rd_ptr_q];
            assign rd_valid = !fifo_empty;
        end else begin : g_std
            logic [DATA_W-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = ra;
                if (ra) begin
                    rd_data_d = mem[rd_ptr_q];
                end
            end

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate
endmodule
